blinkled_pattern_player: RTL and testbench

BLINKLED_PATTERN_PLAYER -- requirements
Module: blinkled_pattern_player

---
 rtl/blinkled_player_pkg.sv | 22 ++
 rtl/blinkled_pattern_player_if.sv | 27 ++
 rtl/blinkled_tick_gen.sv | 35 +++
 rtl/blinkled_pattern_player.sv | 141 ++++++++++++++
 tb/tb_blinkled_pattern_player.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/blinkled_player_pkg.sv
// Shared types and word-format constants for the LED pattern player.
// Holds the FSM state enum, duration field position and end marker.
package blinkled_player_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        HOLD
    } state_e;

    localparam int DUR_MSB = 31;
    localparam int DUR_LSB = 16;

    // A word whose duration field equals this ends the sequence.
    localparam logic [15:0] END_MARKER = 16'h0000;

    function automatic logic [15:0] word_dur(input logic [31:0] w);
        return w[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/blinkled_pattern_player_if.sv
// Pattern RAM read bus between the player (master) and the RAM (slave).
// Ports: mem_address/chipselect/write/clken out, mem_readdata in (1-cycle).
interface blinkled_pattern_player_if;

    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    modport master (
        output mem_address,
        output mem_chipselect,
        output mem_write,
        output mem_clken,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_chipselect,
        input  mem_write,
        input  mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/blinkled_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_DIV clk cycles.
// Ports: clk, reset (async high), clr (restart count), tick (pulse out).
module blinkled_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blinkled_pattern_player.sv
// Plays {duration, pattern} words from a pattern RAM onto the LEDs.
// Ports: clk, reset, start/stop/loop_en/base_addr control, leds, busy,
//        done pulse, and the RAM read bus (mem, master side).
module blinkled_pattern_player
    import blinkled_player_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int LED_W    = 10,
    parameter int DEPTH    = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [15:0]      base_addr,
    output logic [LED_W-1:0] leds,
    output logic             busy,
    output logic             done,
    blinkled_pattern_player_if.master mem
);

    localparam logic [15:0] PTR_LAST = 16'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [15:0]       ptr_q, ptr_d;
    logic [15:0]       base_q, base_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;

    logic              tick;
    logic              pre_clr;
    logic [15:0]       dur;
    logic [15:0]       ptr_next;

    // Pattern bits above LED_W and below the duration field are don't-care.
    logic              unused_rd;
    assign unused_rd = ^mem.mem_readdata;

    blinkled_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .tick  (tick)
    );

    assign dur      = word_dur(mem.mem_readdata);
    assign ptr_next = (ptr_q == PTR_LAST) ? 16'd0 : ptr_q + 16'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        leds_d  = leds_q;
        done_d  = 1'b0;
        pre_clr = 1'b0;
        if (stop) begin
            state_d = IDLE;
            leds_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_d   = base_addr;
                        base_d  = base_addr;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (dur != END_MARKER) begin
                        leds_d  = mem.mem_readdata[LED_W-1:0];
                        cnt_d   = dur;
                        pre_clr = 1'b1;
                        state_d = HOLD;
                    end else if (loop_en) begin
                        ptr_d   = base_q;
                        state_d = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cnt_d = cnt_q - 16'd1;
                        // Last tick of this word: move on.
                        if (cnt_q == 16'd1) begin
                            ptr_d   = ptr_next;
                            state_d = FETCH;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
        cs_d   = (state_d == FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
        end
    end

    assign leds               = leds_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign mem.mem_address    = ptr_q;
    assign mem.mem_chipselect = cs_q;
    assign mem.mem_write      = 1'b0;
    assign mem.mem_clken      = 1'b1;

endmodule

// File: tb/tb_blinkled_pattern_player.sv
// Directed bench for blinkled_pattern_player with a 4-word RAM model.
// Covers reset, playback, looping, wrap, stop, reset and busy start.
module tb_blinkled_pattern_player;

    localparam int TD = 4;
    localparam int LW = 10;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [15:0]   base_addr = 16'd0;
    logic [LW-1:0] leds;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [31:0] ram [0:DP-1];
    logic [15:0] fetch_q [$];

    blinkled_pattern_player_if mif ();

    blinkled_pattern_player #(
        .TICK_DIV (TD),
        .LED_W    (LW),
        .DEPTH    (DP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .base_addr (base_addr),
        .leds      (leds),
        .busy      (busy),
        .done      (done),
        .mem       (mif.master)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data one cycle after the address.
    always @(posedge clk)
        mif.mem_readdata <= ram[mif.mem_address[1:0]];

    always @(posedge clk) begin
        if (mif.mem_chipselect === 1'b1)
            fetch_q.push_back(mif.mem_address);
        if (done === 1'b1)
            done_cnt++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output logic got);
        int n;
        n = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            if (done === 1'b1) got = 1'b1;
            else begin
                cyc();
                n++;
            end
        end
    endtask

    initial begin
        logic got;
        int   n;
        int   nf;

        ram[0] = 32'h0002_0155;
        ram[1] = 32'h0000_0000;
        ram[2] = 32'h0000_0000;
        ram[3] = 32'h0000_0000;

        // Reset state
        cyc();
        chk("rst_outs", 64'({leds, busy, done}), 64'd0);
        chk("rst_cs", 64'(mif.mem_chipselect), 64'd0);
        chk("rst_addr", 64'(mif.mem_address), 64'd0);
        chk("rst_wr_clken", 64'({mif.mem_write, mif.mem_clken}), 64'b01);
        cyc();
        reset = 1'b0;
        cyc();

        // Basic playback
        fetch_q.delete();
        done_cnt = 0;
        base_addr = 16'd0;
        loop_en = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("basic_fetch_cs", 64'(mif.mem_chipselect), 64'd1);
        chk("basic_fetch_addr", 64'(mif.mem_address), 64'd0);
        cyc();
        chk("basic_capture_cs", 64'(mif.mem_chipselect), 64'd0);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("basic_hold", 64'({leds, done, busy}),
                64'({10'h155, 1'b0, 1'b1}));
            cyc();
        end
        wait_done(8, got);
        chk("basic_done_seen", 64'(got), 64'd1);
        chk("basic_done_busy", 64'(busy), 64'd0);
        chk("basic_done_leds", 64'(leds), 64'h155);
        cyc();
        chk("basic_done_pulse", 64'(done), 64'd0);
        chk("basic_fetch_n", 64'(fetch_q.size()), 64'd2);
        chk("basic_fetch_seq", 64'({fetch_q[0], fetch_q[1]}),
            64'({16'd0, 16'd1}));
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);

        // Looping
        fetch_q.delete();
        done_cnt = 0;
        loop_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(40);
        chk("loop_fetch_ge4", 64'(fetch_q.size() >= 4), 64'd1);
        chk("loop_fetch_seq",
            {fetch_q[0], fetch_q[1], fetch_q[2], fetch_q[3]},
            {16'd0, 16'd1, 16'd0, 16'd1});
        chk("loop_no_done", 64'(done_cnt), 64'd0);
        chk("loop_busy", 64'(busy), 64'd1);

        // Stop with simultaneous start while in HOLD
        n = 0;
        while (!(mif.mem_chipselect === 1'b1 &&
                 mif.mem_address === 16'd0) && n < 20) begin
            cyc();
            n++;
        end
        chk("stop_find_fetch", 64'(n < 20), 64'd1);
        cyc(3);
        chk("stop_pre_leds", 64'(leds), 64'h155);
        nf = fetch_q.size();
        stop = 1'b1;
        start = 1'b1;
        base_addr = 16'd2;
        cyc();
        stop = 1'b0;
        start = 1'b0;
        chk("stop_leds_busy", 64'({leds, busy}), 64'd0);
        cyc(10);
        chk("stop_no_fetch", 64'(fetch_q.size()), 64'(nf));
        chk("stop_idle", 64'({busy, done}), 64'd0);
        chk("stop_no_done", 64'(done_cnt), 64'd0);

        // Wrap-around from DEPTH-1 to 0
        ram[3] = 32'h0001_0001;
        ram[0] = 32'h0000_0000;
        fetch_q.delete();
        done_cnt = 0;
        loop_en = 1'b0;
        base_addr = 16'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(30, got);
        chk("wrap_done_seen", 64'(got), 64'd1);
        chk("wrap_fetch_n", 64'(fetch_q.size()), 64'd2);
        chk("wrap_fetch_seq", 64'({fetch_q[0], fetch_q[1]}),
            64'({16'd3, 16'd0}));
        chk("wrap_leds", 64'(leds), 64'h001);

        // Reset during HOLD
        ram[0] = 32'h0002_0155;
        ram[1] = 32'h0000_0000;
        base_addr = 16'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(4);
        chk("rstmid_pre_leds", 64'(leds), 64'h155);
        reset = 1'b1;
        #1;
        chk("rstmid_outs", 64'({leds, busy, done}), 64'd0);
        chk("rstmid_bus",
            64'({mif.mem_chipselect, mif.mem_address}), 64'd0);
        cyc(2);
        reset = 1'b0;
        fetch_q.delete();
        cyc(20);
        chk("rstmid_no_fetch", 64'(fetch_q.size()), 64'd0);
        chk("rstmid_idle", 64'({leds, busy}), 64'd0);

        // Start while busy is ignored
        fetch_q.delete();
        done_cnt = 0;
        base_addr = 16'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(4);
        base_addr = 16'd5;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_ptr", 64'(mif.mem_address), 64'd0);
        chk("busy_state", 64'({leds, busy}), 64'({10'h155, 1'b1}));
        wait_done(20, got);
        chk("busy_done_seen", 64'(got), 64'd1);
        chk("busy_fetch_n", 64'(fetch_q.size()), 64'd2);
        chk("busy_fetch_seq", 64'({fetch_q[0], fetch_q[1]}),
            64'({16'd0, 16'd1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
